// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and pixel-pipeline control word shared by the VGA reader.
package vga_timing_pkg;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int CNT_W = 10;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
      logic win;
      logic en;
   } pix_ctl_t;

   // Idle control word: syncs deasserted, blanked, no image.
   localparam pix_ctl_t CTL_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, win: 1'b0, en: 1'b0};

   function automatic logic in_range(logic [CNT_W-1:0] c, int lo, int hi);
      return int'(c) >= lo && int'(c) < hi;
   endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x525 raster counters with sync, active-area and frame-start generation.
module vga_timing_gen
   import vga_timing_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs,
   output logic             vs,
   output logic             active,
   output logic             frame_start
);
   logic             run;
   logic             h_last;
   logic             v_last;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;

   // The first edge after reset holds the raster at (0,0) so frame_start can be raised with it.
   always_comb begin
      h_last = h_cnt == CNT_W'(H_TOTAL - 1);
      v_last = v_cnt == CNT_W'(V_TOTAL - 1);
      h_nxt  = (!run || h_last) ? '0 : h_cnt + 1'b1;
      v_nxt  = !run ? '0 : h_last ? (v_last ? '0 : v_cnt + 1'b1) : v_cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run         <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         run         <= 1'b1;
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         frame_start <= h_nxt == '0 && v_nxt == '0;
      end
   end

   assign hs     = !in_range(h_cnt, H_SYNC_START, H_SYNC_END);
   assign vs     = !in_range(v_cnt, V_SYNC_START, V_SYNC_END);
   assign active = in_range(h_cnt, 0, H_ACTIVE) && in_range(v_cnt, 0, V_ACTIVE);
endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: streams a centred framebuffer image onto 640x480 VGA, padding the border with black.
module vga_fb_reader
   import vga_timing_pkg::*;
#(
   parameter int IMG_W   = 160,
   parameter int IMG_H   = 120,
   parameter int ADDR_W  = 15,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fb_ready,
   input  logic [7:0]        ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        vga_pixel,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank_n,
   output logic              frame_start
);
   localparam int X0 = (H_ACTIVE - IMG_W) / 2;
   localparam int Y0 = (V_ACTIVE - IMG_H) / 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             hs;
   logic             vs;
   logic             active;
   logic             in_win;
   logic             en;
   pix_ctl_t         cur;
   pix_ctl_t         dly [RAM_LAT];
   pix_ctl_t         last;

   vga_timing_gen u_timing (
      .clk         (clk),
      .rst         (rst),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .hs          (hs),
      .vs          (vs),
      .active      (active),
      .frame_start (frame_start)
   );

   assign in_win = in_range(h_cnt, X0, X0 + IMG_W) && in_range(v_cnt, Y0, Y0 + IMG_H);
   assign cur    = '{hs: hs, vs: vs, blank_n: active, win: in_win, en: en};
   assign last   = dly[RAM_LAT-1];

   // Raster-order address counter; parks at 0 once the last image pixel has been fetched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr <= '0;
         en       <= 1'b0;
      end else begin
         en       <= frame_start ? fb_ready : en;
         ram_addr <= (frame_start || (in_win && ram_addr == LAST_ADDR)) ? '0 :
                     in_win ? ram_addr + 1'b1 : ram_addr;
      end
   end

   // Control travels alongside the RAM read so it meets ram_data in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RAM_LAT; i++) dly[i] <= CTL_RST;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_pixel   <= '0;
      end else begin
         dly[0] <= cur;
         for (int i = 1; i < RAM_LAT; i++) dly[i] <= dly[i-1];
         vga_hs      <= last.hs;
         vga_vs      <= last.vs;
         vga_blank_n <= last.blank_n;
         vga_pixel   <= (last.win && last.en && last.blank_n) ? ram_data : '0;
      end
   end
endmodule

// File: doc/vga_fb_reader.md
VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 160, image width in pixels held in the framebuffer.
REQ-002 SHALL have parameter IMG_H, default 120, image height in pixels held in the framebuffer.
REQ-003 SHALL have parameter ADDR_W, default 15, framebuffer address width; IMG_W*IMG_H <= 2**ADDR_W.
REQ-004 SHALL have parameter RAM_LAT, default 1, framebuffer read latency in cycles, legal range 1..3.
REQ-005 SHALL have port clk  input  1  pixel clock, 25 MHz, one pixel per cycle.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port fb_ready  input  1  framebuffer holds a complete image; display enabled.
REQ-008 SHALL have port ram_data  input  8  framebuffer read data, valid RAM_LAT cycles after ram_addr.
REQ-009 SHALL have port ram_addr  output  ADDR_W  framebuffer read address.
REQ-010 SHALL have port vga_pixel  output  8  grayscale pixel to DAC.
REQ-011 SHALL have port vga_hs  output  1  horizontal sync, active-low.
REQ-012 SHALL have port vga_vs  output  1  vertical sync, active-low.
REQ-013 SHALL have port vga_blank_n  output  1  high during the 640x480 active area.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse when h_cnt=0 and v_cnt=0.

Function
REQ-015 SHALL run h_cnt 0..799, then wrap to 0 and advance v_cnt 0..524, then wrap v_cnt to 0.
REQ-016 Horizontal timing SHALL be: active 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-017 Vertical timing SHALL be: active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-018 Image window SHALL be centred: X0=(640-IMG_W)/2, Y0=(480-IMG_H)/2; in_win = X0<=h_cnt<X0+IMG_W and Y0<=v_cnt<Y0+IMG_H.
REQ-019 ram_addr SHALL be produced by an incrementing counter, with no multiplier: +1 on each in_win cycle; cleared to 0 on frame_start.
REQ-020 After the last window pixel (address IMG_W*IMG_H-1), ram_addr SHALL hold at 0 until the next frame.
REQ-021 A display-enable flag SHALL sample fb_ready only on the frame_start cycle; changes mid-frame SHALL take effect at the next frame only.
REQ-022 hs, vs, blank_n and in_win SHALL be delayed by RAM_LAT stages so they stay aligned with ram_data.
REQ-023 All outputs SHALL be registered; total latency from counter state to vga_* SHALL be RAM_LAT+1 cycles.
REQ-024 vga_pixel SHALL equal ram_data when delayed in_win and display-enable are both 1, and 0x00 otherwise, including the border.
REQ-025 vga_blank_n SHALL be 0 outside the active area; vga_pixel SHALL be 0x00 whenever vga_blank_n=0.
REQ-026 frame_start SHALL be undelayed (counter stage), so the upstream writer can use it for synchronisation.
REQ-027 Border checks SHALL use the fixed compares h_cnt==799 and v_cnt==524, with no off-by-one at either wrap.

Reset
REQ-028 On rst: h_cnt=0, v_cnt=0, ram_addr=0, display-enable=0, all delay stages cleared.
REQ-029 Outputs on rst SHALL be: vga_hs=1, vga_vs=1, vga_blank_n=0, vga_pixel=0x00, frame_start=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; the first cycle after release SHALL be h_cnt=0, v_cnt=0 with frame_start=1.

Structure
REQ-031 The 640x480 timing constants (active, porches, sync widths, totals) SHALL live in shared package vga_timing_pkg.
REQ-032 Counters and sync generation SHALL be the sub-module vga_timing_gen (clk, rst -> h_cnt, v_cnt, hs, vs, active, frame_start).
REQ-033 Address generation, the delay line and output muxing SHALL live in the top level.

Verification
REQ-034 Release rst, run one frame -> vga_hs low for exactly 96 cycles per line; vga_vs low for exactly 2 lines (1600 cycles); frame period 420000 cycles.
REQ-035 fb_ready=1, ram model returns data=addr[7:0], RAM_LAT=1 -> at screen line 180 (Y0), column 240 (X0), vga_pixel=0x00 first, then 0x01, ...; final pixel's ram_addr=19199.
REQ-036 fb_ready=0 for the whole frame -> vga_pixel=0x00 on all 307200 active pixels, while sync timing is unchanged.
REQ-037 fb_ready rises at h=300, v=200 -> that frame stays black; the next frame shows the image.
REQ-038 Assert rst at h=400, v=250 for 3 cycles -> outputs are at reset values during rst; after release, frame_start=1 on the first cycle and ram_addr=0.
REQ-039 Repeat the REQ-035 run with RAM_LAT=3 -> first window pixel and vga_blank_n stay aligned; vga_pixel transitions occur 4 cycles after the counter reaches the pixel.
